// File: rtl/rr_onehot_arbiter_if.sv
// rr_onehot_arbiter_if: request/grant bundle between requesters and the round-robin arbiter
interface rr_onehot_arbiter_if;
    logic [7:0] req;
    logic [7:0] grant;
    logic       grant_valid;
    logic       grant_new;
    modport master (output req, input grant, input grant_valid, input grant_new);
    modport slave (input req, output grant, output grant_valid, output grant_new);
endinterface

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: eight-way round-robin arbiter with bounded grant hold and registered one-hot grant
module rr_onehot_arbiter #(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input logic               clock,
    input logic               reset,
    rr_onehot_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_e;
    state_e            state_q, state_d;
    logic [7:0]        grant_q, grant_d, cand;
    logic [2:0]        ptr_q, ptr_d, win, idx;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              new_q, new_d, valid_q, found, release_h, hold_max, repick;

    // The holder is masked out, so one scan serves both release and preemption.
    always_comb begin
        cand  = state_q == GRANT ? bus.req & ~grant_q : bus.req;
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int k = 1; k <= 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign hold_max  = hold_q == HOLD_W'(MAX_HOLD - 1);
    assign release_h = ~|(bus.req & grant_q);
    assign repick    = state_q == IDLE || release_h || (hold_max && found);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        hold_d  = hold_max ? hold_q : hold_q + 1'b1;
        new_d   = 1'b0;
        if (repick) begin
            state_d = found ? GRANT : IDLE;
            grant_d = found ? 8'b1 << win : 8'h00;
            ptr_d   = found ? win : ptr_q;
            hold_d  = '0;
            new_d   = found;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 8'h00;
            ptr_q   <= 3'd7;
            hold_q  <= '0;
            new_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            new_q   <= new_d;
            valid_q <= |grant_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = valid_q;
    assign bus.grant_new   = new_q;
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb_rr_onehot_arbiter: directed plan scenarios plus randomized traffic against a behavioural arbiter model
module tb_rr_onehot_arbiter;
    localparam int MAX_HOLD = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    rr_onehot_arbiter_if bus ();
    rr_onehot_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(3)) dut (.clock(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: holder index (-1 idle), last granted index, cycles the holder has held so far.
    int   holder = -1;
    int   last = 7;
    int   held = 0;
    int   pick;
    bit   mnew = 1'b0;
    bit   started = 1'b0;
    logic [7:0] hmask;

    always @(posedge clk) begin
        if (rst) begin
            holder  = -1;
            last    = 7;
            held    = 0;
            mnew    = 1'b0;
            started = 1'b1;
        end else begin
            hmask = holder < 0 ? 8'h00 : 8'(1 << holder);
            if (holder < 0 || !bus.req[holder] || (held >= MAX_HOLD && (bus.req & ~hmask) != 8'h00)) begin
                pick = -1;
                for (int k = 1; k <= 8; k++)
                    if (pick < 0 && bus.req[(last + k) % 8] && (last + k) % 8 != holder) pick = (last + k) % 8;
                if (pick >= 0) begin
                    holder = pick;
                    last   = pick;
                    held   = 1;
                    mnew   = 1'b1;
                end else begin
                    holder = -1;
                    held   = 0;
                    mnew   = 1'b0;
                end
            end else begin
                held = held < MAX_HOLD ? held + 1 : held;
                mnew = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_grant", bus.grant, holder < 0 ? 8'h00 : 8'(1 << holder));
            chk("model_valid", {7'd0, bus.grant_valid}, {7'd0, holder >= 0});
            chk("model_new", {7'd0, bus.grant_new}, {7'd0, mnew});
            chk("onehot", {7'd0, $countones(bus.grant) <= 1}, 8'h01);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 8'h00;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        bus.req = 8'h00;
        tick(2);
        chk("reset_grant", bus.grant, 8'h00);
        chk("reset_valid", {7'd0, bus.grant_valid}, 8'h00);
        chk("reset_new", {7'd0, bus.grant_new}, 8'h00);
        rst = 1'b0;
        // single request
        bus.req = 8'h10;
        tick(1);
        chk("single_grant", bus.grant, 8'h10);
        chk("single_new", {7'd0, bus.grant_new}, 8'h01);
        tick(1);
        chk("single_hold", bus.grant, 8'h10);
        chk("single_new_drop", {7'd0, bus.grant_new}, 8'h00);
        // priority after reset, release handoff
        do_reset();
        bus.req = 8'h81;
        tick(1);
        chk("prio_first", bus.grant, 8'h01);
        bus.req = 8'h80;
        tick(1);
        chk("prio_release", bus.grant, 8'h80);
        bus.req = 8'h00;
        tick(1);
        chk("prio_idle", bus.grant, 8'h00);
        chk("prio_idle_valid", {7'd0, bus.grant_valid}, 8'h00);
        // preempt rotation under full contention
        do_reset();
        bus.req = 8'hFF;
        for (int c = 0; c < 36; c++) begin
            tick(1);
            chk("rotate_grant", bus.grant, 8'(1 << ((c / 4) % 8)));
            chk("rotate_new", {7'd0, bus.grant_new}, {7'd0, c % 4 == 0});
        end
        // wrap-around preemption from holder 6
        do_reset();
        bus.req = 8'h40;
        tick(1);
        chk("wrap_h6", bus.grant, 8'h40);
        bus.req = 8'h43;
        tick(3);
        chk("wrap_still6", bus.grant, 8'h40);
        tick(1);
        chk("wrap_to0", bus.grant, 8'h01);
        // no-contention hold
        do_reset();
        bus.req = 8'h04;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            chk("solo_grant", bus.grant, 8'h04);
            chk("solo_new", {7'd0, bus.grant_new}, {7'd0, c == 0});
        end
        // reset mid-grant
        bus.req = 8'h20;
        tick(3);
        chk("midrst_pre", bus.grant, 8'h20);
        rst = 1'b1;
        tick(1);
        chk("midrst_drop", bus.grant, 8'h00);
        rst = 1'b0;
        tick(1);
        chk("midrst_regrant", bus.grant, 8'h20);
        chk("midrst_new", {7'd0, bus.grant_new}, 8'h01);
        // randomized traffic, model checked every cycle
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0)
                bus.req = $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom);
            else if ($urandom_range(0, 5) == 0)
                bus.req = bus.req & ~(8'h01 << $urandom_range(0, 7));
            rst = $urandom_range(0, 199) == 0;
            tick(1);
        end
        rst = 1'b0;
        tick(1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
